// File: rtl/jt12_cic_pkg.sv
// CIC integrator helpers: internal width, shift amount, saturation.
// Shared by the integrator top and its accumulator stage.
package jt12_cic_pkg;

  localparam int DEF_N  = 2;
  localparam int DEF_RB = 2;
  localparam int DEF_SH = (DEF_N - 1) * DEF_RB;

  function automatic int cic_wi(input int w, input int n, input int rb);
    return w + n * rb;
  endfunction

  // Removes the R^(N-1) integrator gain.
  function automatic int cic_sh(input int n, input int rb);
    return (n - 1) * rb;
  endfunction

  function automatic logic signed [63:0] sat_w(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/jt12_cic_integ_if.sv
// Sample bus between comb chain, integrator and mixer.
// master drives strobes + snd_in; slave returns snd_out + ovf.
interface jt12_cic_integ_if #(
  parameter int W = 16
);
  logic                cen_in;
  logic                cen_out;
  logic signed [W-1:0] snd_in;
  logic signed [W-1:0] snd_out;
  logic                ovf;

  modport master (
    output cen_in, cen_out, snd_in,
    input  snd_out, ovf
  );

  modport slave (
    input  cen_in, cen_out, snd_in,
    output snd_out, ovf
  );
endinterface

// File: rtl/jt12_cic_integ_stage.sv
// One wrapping enabled accumulator of the CIC integrator chain.
// Ports: clk, rst_n, cen (update enable), din (addend), dout (state).
module jt12_cic_integ_stage #(
  parameter int WI = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic signed [WI-1:0] din,
  output logic signed [WI-1:0] dout
);

  logic signed [WI-1:0] acc_q;
  logic signed [WI-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (cen) acc_d = acc_q + din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign dout = acc_q;

endmodule

// File: rtl/jt12_cic_integ.sv
// CIC interpolator back half: capture, zero-stuff, N integrators, rescale.
// Ports: clk, rst_n, bus (slave: cen_in, cen_out, snd_in -> snd_out, ovf).
module jt12_cic_integ
  import jt12_cic_pkg::*;
#(
  parameter int W  = 16,
  parameter int N  = 2,
  parameter int RB = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  jt12_cic_integ_if.slave bus
);

  localparam int WI = cic_wi(W, N, RB);
  localparam int SH = cic_sh(N, RB);

  logic signed [W-1:0]  hold_q, hold_d;
  logic                 pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic signed [W-1:0]  snd_q, snd_d;
  logic signed [WI-1:0] x;
  logic signed [WI-1:0] din_w [N];
  logic signed [WI-1:0] acc_w [N];

  // cen_out reads the old hold before cen_in replaces it.
  always_comb begin
    hold_d = hold_q;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    x      = '0;
    if (bus.cen_out) begin
      if (pend_q) x = WI'(hold_q);
      pend_d = 1'b0;
    end
    if (bus.cen_in) begin
      hold_d = bus.snd_in;
      pend_d = 1'b1;
      if (pend_q && !bus.cen_out) ovf_d = 1'b1;
    end
  end

  always_comb begin
    din_w[0] = x;
    for (int k = 1; k < N; k++) din_w[k] = acc_w[k-1];
  end

  for (genvar k = 0; k < N; k++) begin : g_int
    jt12_cic_integ_stage #(
      .WI (WI)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .cen   (bus.cen_out),
      .din   (din_w[k]),
      .dout  (acc_w[k])
    );
  end

  always_comb begin
    snd_d = snd_q;
    if (bus.cen_out)
      snd_d = W'(sat_w(64'(acc_w[N-1]) >>> SH, W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      snd_q  <= '0;
    end else begin
      hold_q <= hold_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      snd_q  <= snd_d;
    end
  end

  assign bus.snd_out = snd_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_jt12_cic_integ.sv
// Directed bench for jt12_cic_integ with W=16, N=2, RB=2.
// Each task drives one scenario and checks snd_out/ovf inline.
module tb_jt12_cic_integ;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  jt12_cic_integ_if #(.W(16)) bus ();

  jt12_cic_integ #(
    .W  (16),
    .N  (2),
    .RB (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick(input logic ci, input logic co,
                      input logic signed [15:0] d);
    @(negedge clk);
    bus.cen_in  = ci;
    bus.cen_out = co;
    bus.snd_in  = d;
    @(negedge clk);
    bus.cen_in  = 1'b0;
    bus.cen_out = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    n_run++;
    if (bus.snd_out !== 16'sd0 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: snd_out=%0d ovf=%b want 0 0",
               bus.snd_out, bus.ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_step();
    logic signed [15:0] exp_v [1:8];
    exp_v = '{16'sd0, 16'sd0, 16'sd25, 16'sd50,
              16'sd75, 16'sd100, 16'sd100, 16'sd100};
    do_reset();
    tick(1'b1, 1'b0, 16'sd100);
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) tick(1'b1, 1'b0, -16'sd100);
      tick(1'b0, 1'b1, 16'sd0);
      n_run++;
      if (bus.snd_out !== exp_v[k]) begin
        n_fail++;
        $display("FAIL step#%0d: snd_out=%0d want %0d",
                 k, bus.snd_out, exp_v[k]);
      end
    end
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 16'sh7abc);
    n_run++;
    if (bus.snd_out !== 16'sd100 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL step_idle: snd_out=%0d ovf=%b want 100 0",
               bus.snd_out, bus.ovf);
    end
  endtask

  task automatic test_zero();
    int bad;
    bad = 0;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      tick((k % 4) == 0, 1'b1, 16'sd0);
      n_run++;
      if (bus.snd_out !== 16'sd0) begin
        n_fail++;
        bad++;
        if (bad < 4)
          $display("FAIL zero#%0d: snd_out=%0d want 0",
                   k + 1, bus.snd_out);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] exp_v [1:8];
    exp_v = '{16'sd0, 16'sd0, 16'sd0, 16'sd8191,
              16'sd16383, 16'sd24575, 16'sd32767, 16'sd32767};
    do_reset();
    // cen_in lands on cen_out #1, so the sample is consumed at #2.
    tick(1'b1, 1'b1, 16'sd32767);
    n_run++;
    if (bus.snd_out !== exp_v[1]) begin
      n_fail++;
      $display("FAIL sat#1: snd_out=%0d want %0d",
               bus.snd_out, exp_v[1]);
    end
    for (int k = 2; k <= 8; k++) begin
      tick(1'b0, 1'b1, 16'sd0);
      n_run++;
      if (bus.snd_out !== exp_v[k]) begin
        n_fail++;
        $display("FAIL sat#%0d: snd_out=%0d want %0d",
                 k, bus.snd_out, exp_v[k]);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    tick(1'b1, 1'b0, 16'sd10);
    n_run++;
    if (bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first: ovf=%b want 0", bus.ovf);
    end
    tick(1'b1, 1'b0, 16'sd20);
    n_run++;
    if (bus.ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_set: ovf=%b want 1", bus.ovf);
    end
    // int0=20 after #1, int1=20 after #2, snd_out=20>>>2=5 at #3.
    tick(1'b0, 1'b1, 16'sd0);
    tick(1'b0, 1'b1, 16'sd0);
    tick(1'b0, 1'b1, 16'sd0);
    n_run++;
    if (bus.snd_out !== 16'sd5) begin
      n_fail++;
      $display("FAIL ovr_value: snd_out=%0d want 5", bus.snd_out);
    end
    n_run++;
    if (bus.ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: ovf=%b want 1", bus.ovf);
    end
  endtask

  task automatic test_simultaneous();
    logic signed [15:0] exp_v [2:5];
    // int0: 5, 12, 12, 12; int1: 0, 5, 17, 29.
    exp_v = '{16'sd0, 16'sd1, 16'sd4, 16'sd7};
    do_reset();
    tick(1'b1, 1'b0, 16'sd5);
    tick(1'b1, 1'b1, 16'sd7);
    n_run++;
    if (bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_ovf: ovf=%b want 0", bus.ovf);
    end
    for (int k = 2; k <= 5; k++) begin
      tick(1'b0, 1'b1, 16'sd0);
      n_run++;
      if (bus.snd_out !== exp_v[k]) begin
        n_fail++;
        $display("FAIL simul#%0d: snd_out=%0d want %0d",
                 k, bus.snd_out, exp_v[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b1, 1'b0, 16'sd100);
    for (int k = 1; k <= 4; k++) tick(1'b0, 1'b1, 16'sd0);
    n_run++;
    if (bus.snd_out !== 16'sd50) begin
      n_fail++;
      $display("FAIL rmid_pre: snd_out=%0d want 50", bus.snd_out);
    end
    tick(1'b1, 1'b0, -16'sd100);
    tick(1'b1, 1'b0, 16'sd300);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    n_run++;
    if (bus.snd_out !== 16'sd0 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async: snd_out=%0d ovf=%b want 0 0",
               bus.snd_out, bus.ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1'b0, 1'b1, 16'sd0);
      n_run++;
      if (bus.snd_out !== 16'sd0) begin
        n_fail++;
        $display("FAIL rmid_post#%0d: snd_out=%0d want 0",
                 k, bus.snd_out);
      end
    end
  endtask

  initial begin
    bus.cen_in  = 1'b0;
    bus.cen_out = 1'b0;
    bus.snd_in  = 16'sd0;
    #1;
    test_reset();
    test_step();
    test_zero();
    test_saturation();
    test_overrun();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/jt12_cic_integ.md
Name: jt12_cic_integ

Overview:
- Integrator/upsampler back half of a CIC interpolator. Sits directly downstream of the comb chain (N first-order combs at input rate).
- Captures comb output at the low-rate strobe and zero-stuffs it to the high-rate strobe.
- Runs N wrapping integrators at the high rate, then rescales by the CIC gain and saturates back to W bits for the mixer/DAC path.

Parameters:
- W, 16: signed sample width in and out.
- N, 2: number of integrator stages (1..4). Must equal the upstream comb count.
- RB, 2: log2 of the upsample ratio R = 2^RB (1..4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen_in  in  1  low-rate strobe; snd_in is valid on this cycle
- cen_out  in  1  high-rate strobe; nominally R pulses per cen_in period
- snd_in  in  W  signed comb-chain output
- snd_out  out  W  signed interpolated sample, updated only on cen_out
- ovf  out  1  sticky overrun flag

Behaviour:
- Reset: all async on rst_n low. snd_out=0, ovf=0, hold=0, pending=0, all integrators=0. Reset mid-operation discards any pending sample and integrator state.
- Internal width: WI = W + N*RB. All integrator arithmetic is two's-complement modulo 2^WI. Wrap is intentional; never saturate inside the integrators.
- Capture: on cen_in, hold <= snd_in and pending <= 1.
- Overrun: cen_in while pending=1 and no cen_out in the same cycle. hold is overwritten, ovf <= 1. ovf clears only on reset.
- Feed: on cen_out, x = pending ? sign-extend(hold) : 0, and pending <= 0.
- Simultaneous cen_in and cen_out:
  - cen_out consumes the old hold (or 0 if pending was 0).
  - cen_in loads the new sample; pending ends at 1.
  - No overrun is flagged.
- Integrators, all registered and updated only on cen_out:
  - int[0] <= int[0] + x
  - int[k] <= int[k] + int[k-1], using the pre-edge value of int[k-1], for k = 1..N-1
- Output: on cen_out, snd_out <= sat_W(int[N-1] >>> ((N-1)*RB)). The arithmetic shift removes the gain R^(N-1). sat_W clamps to [-2^(W-1), 2^(W-1)-1].
- Latency: a sample consumed at cen_out #1 first affects snd_out at cen_out #(N+1).
- Idle behaviour: with neither strobe asserted, all state holds.
- cen_in and cen_out need not be phase-locked. Only the overrun rule governs their interaction.

Decomposition:
- Package jt12_cic_pkg holds:
  - the width function WI(W,N,RB)
  - the saturating-truncate function sat_W
  - a localparam for the shift amount (N-1)*RB
- Sub-module jt12_cic_integ_stage: one WI-bit enabled accumulator (rst_n, clk, cen, din, dout). Instantiated N times in a generate loop.
- Capture/pending logic and the output scaler stay in the top module.

Test Plan:
All cases use W=16, N=2, RB=2 (WI=20), with cen_in every 4th cen_out unless stated.
- Step response: feed comb outputs 100, -100, 0, 0… -> snd_out after cen_out #3..#6 = 25, 50, 75, 100, then holds at 100. ovf stays 0.
- Latency/zero: feed 0 continuously after reset -> snd_out stays 0 for 64 cen_out pulses. Integrators stay 0.
- Saturation: feed 32767 then only zeros (no cancelling sample) -> int[1] ramps 0, 32767, 65534… snd_out = 24575 at #6 and 32767 (clamped) at #7 and #8.
- Overrun: two cen_in pulses (10, then 20) with no cen_out between -> ovf=1 and stays 1. The next cen_out consumes 20 (int[0]=20).
- Simultaneous strobes: with pending=1, hold=5, assert cen_in (snd_in=7) and cen_out together -> int[0] += 5, pending=1, hold=7, ovf=0. The next cen_out adds 7.
- Reset mid-run: during the step test, pulse rst_n low between #4 and #5 -> snd_out, ovf, int[*] and pending read 0 immediately. The first cen_out after release gives snd_out=0.
